// File: rtl/stall_flush_ctrl.sv
// rtl/stall_flush_ctrl.sv - pipeline stall/flush controller for the 5-stage CPU
//
// Merges ID/EX/MEM stall requests into the stall bus, sequences multi-cycle
// EX operations with a down-counter, and turns MEM exceptions into a
// one-cycle flush with a redirect PC.
//
// Optional feature macro: STALL_CTRL_PERF_EN (stall-cycle performance counter).
//
// Ports:
//   clk               rising-edge clock
//   rst               synchronous, active-high reset
//   stallreq_from_id  load-use hazard request (combinational)
//   stallreq_from_ex  generic EX stall request (combinational)
//   stallreq_from_mem data SRAM not ready (combinational)
//   mc_start          one-cycle pulse starting a multi-cycle EX op
//   mc_cycles         stall cycles for the op, sampled with mc_start
//   mc_done           registered one-cycle pulse: op result may advance
//   mc_busy           registered; high in MC_BUSY or MC_HOLD
//   excp_req          exception request from MEM
//   excp_pc           redirect PC, valid with excp_req
//   flush             registered one-cycle flush of IF..MEM
//   new_pc            registered redirect PC, valid with flush
//   stall             combinational stall bus {WB,MEM,EX,ID,IF,PC}
//   perf_stall_cnt    stalled-cycle counter (zero when feature disabled)

module stall_flush_ctrl #(
    parameter int STALL_W = 6,
    parameter int CNT_W   = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stallreq_from_id,
    input  logic               stallreq_from_ex,
    input  logic               stallreq_from_mem,
    input  logic               mc_start,
    input  logic [CNT_W-1:0]   mc_cycles,
    output logic               mc_done,
    output logic               mc_busy,
    input  logic               excp_req,
    input  logic [31:0]        excp_pc,
    output logic               flush,
    output logic [31:0]        new_pc,
    output logic [STALL_W-1:0] stall,
    output logic [31:0]        perf_stall_cnt
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MC_BUSY = 2'd1,
        MC_HOLD = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] counter;
    logic [CNT_W-1:0] cnt_dec;
    logic [CNT_W-1:0] start_rem;
    logic             mc_stall;

    // Cycles still to spend in MC_BUSY after the start cycle; a zero count
    // is treated as a one-cycle op, so nothing remains after the start cycle.
    assign start_rem = (mc_cycles == '0) ? '0 : mc_cycles - CNT_W'(1);
    assign cnt_dec   = counter - CNT_W'(1);

    // The start cycle itself already stalls EX; an exception in the same
    // cycle cancels the op, so it does not count as a multi-cycle stall.
    assign mc_stall = (state == MC_BUSY) ||
                      ((state == IDLE) && mc_start && !excp_req);

    always_comb begin
        stall = '0;
        if (flush)
            stall = '0;
        else if (stallreq_from_mem)
            stall = STALL_W'(6'b011111);
        else if (stallreq_from_ex || mc_stall)
            stall = STALL_W'(6'b001111);
        else if (stallreq_from_id)
            stall = STALL_W'(6'b000111);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            counter <= '0;
            mc_done <= 1'b0;
            mc_busy <= 1'b0;
            flush   <= 1'b0;
            new_pc  <= 32'h0;
        end else begin
            flush   <= 1'b0;
            mc_done <= 1'b0;
            if (excp_req) begin
                // Exception aborts any multi-cycle op without a done pulse.
                flush   <= 1'b1;
                new_pc  <= excp_pc;
                state   <= IDLE;
                counter <= '0;
                mc_busy <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (mc_start) begin
                            if (start_rem == '0) begin
                                // Single-cycle op: completes on the start edge.
                                if (stallreq_from_mem) begin
                                    state   <= MC_HOLD;
                                    mc_busy <= 1'b1;
                                end else begin
                                    mc_done <= 1'b1;
                                end
                            end else begin
                                counter <= start_rem;
                                state   <= MC_BUSY;
                                mc_busy <= 1'b1;
                            end
                        end
                    end
                    MC_BUSY: begin
                        // Counts down even under a MEM stall; the last busy
                        // cycle is the one whose decrement reaches zero.
                        counter <= cnt_dec;
                        if (cnt_dec == '0) begin
                            if (stallreq_from_mem) begin
                                state <= MC_HOLD;
                            end else begin
                                state   <= IDLE;
                                mc_done <= 1'b1;
                                mc_busy <= 1'b0;
                            end
                        end
                    end
                    MC_HOLD: begin
                        if (!stallreq_from_mem) begin
                            state   <= IDLE;
                            mc_done <= 1'b1;
                            mc_busy <= 1'b0;
                        end
                    end
                    default: begin
                        state   <= IDLE;
                        mc_busy <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef STALL_CTRL_PERF_EN
    logic [31:0] perf_q;

    always_ff @(posedge clk) begin
        if (rst)
            perf_q <= 32'h0;
        else if (stall != '0)
            perf_q <= perf_q + 32'd1;
    end

    assign perf_stall_cnt = perf_q;
`else
    assign perf_stall_cnt = 32'h0;
`endif

endmodule

// File: doc/stall_flush_ctrl.md
Name: stall_flush_ctrl

Overview:
Central pipeline controller for the 5-stage CPU (IF/ID/EX/MEM/WB). Merges stall requests from ID, EX and MEM into the stall bus. Sequences multi-cycle EX operations (mul/div) with a down-counter. Converts exception requests from MEM into a one-cycle flush with a redirect PC.

Parameters:
STALL_W, 6, stall bus width; bit0 = PC, bit1 = IF, bit2 = ID, bit3 = EX, bit4 = MEM, bit5 = WB; 1 = hold that stage register
CNT_W, 6, width of the multi-cycle count

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, synchronous, active-high
stallreq_from_id  in  1  load-use hazard; combinational, same cycle
stallreq_from_ex  in  1  generic EX stall; combinational
stallreq_from_mem  in  1  data SRAM not ready; combinational
mc_start  in  1  one-cycle pulse: EX begins multi-cycle op
mc_cycles  in  CNT_W  total stall cycles for the op, sampled with mc_start
mc_done  out  1  registered; one-cycle pulse when op result may advance
mc_busy  out  1  registered; 1 while in MC_BUSY or MC_HOLD
excp_req  in  1  exception detected in MEM
excp_pc  in  32  handler/redirect PC, valid with excp_req
flush  out  1  registered; kill IF..MEM stage registers
new_pc  out  32  registered; redirect PC, valid when flush=1
stall  out  STALL_W  combinational stall bus
perf_stall_cnt  out  32  stall-cycle counter (optional feature)

Behaviour:
- Reset values: flush=0, new_pc=32'h0, mc_done=0, mc_busy=0, counter=0, state=IDLE, perf_stall_cnt=0.
- Stall patterns, priority high to low:
  - flush=1 -> 6'b000000
  - mem request -> 6'b011111
  - EX request or multi-cycle stall -> 6'b001111
  - ID request -> 6'b000111
  - none -> 0
- FSM states: IDLE, MC_BUSY, MC_HOLD.
- IDLE + mc_start:
  - Effective count N = mc_cycles, or 1 if mc_cycles=0.
  - Load counter with N-1 and go to MC_BUSY.
  - EX stall is asserted combinationally in the mc_start cycle itself.
- MC_BUSY:
  - EX stall asserted every cycle; counter decrements each cycle regardless of MEM stall.
  - When counter=0 at a clock edge: if stallreq_from_mem=0 -> pulse mc_done next cycle and go to IDLE; else go to MC_HOLD.
  - Result: exactly N stall cycles, then mc_done.
- MC_HOLD:
  - No EX stall from this block; the MEM stall still freezes the pipe.
  - Go to IDLE and pulse mc_done on the first edge with stallreq_from_mem=0.
- mc_start while not IDLE is ignored (protocol error; the bench flags it).
- mc_busy = 1 in MC_BUSY or MC_HOLD.
- Exception: excp_req sampled at an edge ->
  - next cycle flush=1 and new_pc=excp_pc, exactly one cycle;
  - FSM forced to IDLE, counter cleared, no mc_done.
- excp_req in consecutive cycles -> flush stays high, new_pc tracks the latest excp_pc.
- excp_req and mc_start in the same cycle: exception wins and the FSM stays IDLE.
- excp_req is accepted even while stallreq_from_mem is active.
- rst mid-operation returns everything to reset values on the next edge and drops any pending mc_done.

Optional Feature:
STALL_CTRL_PERF_EN
- Defined: perf_stall_cnt increments by 1 on every edge where stall!=0, wraps at 2^32, and clears on rst.
- Undefined: no counter logic; perf_stall_cnt is tied to 32'h0.

Test Plan:
- Idle with only stallreq_from_id=1 -> stall=6'b000111; add stallreq_from_mem=1 -> stall=6'b011111.
- mc_start with mc_cycles=4, no other requests -> stall=6'b001111 for exactly 4 cycles (start cycle included); mc_done=1 in cycle 4 only; mc_busy=1 in cycles 1-3.
- mc_start with mc_cycles=0 -> 1 stall cycle, mc_done in the following cycle.
- mc_cycles=3 with stallreq_from_mem=1 from cycle 2 to cycle 5 -> FSM in MC_HOLD; mc_done pulses one cycle after stallreq_from_mem falls; stall=6'b011111 while the mem request is held.
- Mid MC_BUSY (mc_cycles=10, cycle 3) excp_req=1, excp_pc=32'hBFC00380 -> next cycle flush=1, new_pc=32'hBFC00380, stall=0; mc_busy=0; no mc_done ever.
- rst asserted during MC_BUSY -> next cycle all outputs at reset values. With STALL_CTRL_PERF_EN defined, 7 stalled cycles read perf_stall_cnt=7.
